// File: rtl/cpu_mem_router_pkg.sv
// Shared decode constants and the read-source encoding for the cpu memory router.
package cpu_mem_router_pkg;

   localparam logic [1:0] IO_SEL      = 2'b11;
   localparam logic [2:0] IO_OFF_UART = 3'd0;
   localparam logic [2:0] IO_OFF_CTRL = 3'd4;

   typedef enum logic [1:0] {
      SRC_ZERO = 2'd0,
      SRC_RAM  = 2'd1,
      SRC_RX   = 2'd2,
      SRC_STAT = 2'd3
   } rd_src_e;

   function automatic logic [7:0] status_byte(input logic tx_full, input logic rx_full);
      return {6'b0, tx_full, rx_full};
   endfunction

endpackage

// File: rtl/cpu_mem_router_byte_fifo.sv
// Circular byte FIFO with wrap-bit pointers; output is the registered head entry (no bypass).
module byte_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PW = $clog2(DEPTH);

   logic [PW:0]      wr_ptr_q, wr_ptr_d;
   logic [PW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign dout_o  = mem_q[rd_ptr_q[PW-1:0]];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is never reset; stale entries are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= din_i;
   end

endmodule

// File: rtl/cpu_mem_router.sv
// Routes the cpu byte port to RAM or the UART/status/halt I/O window with uniform
// 1-cycle read latency, stalling the cpu while an I/O access cannot complete.
module cpu_mem_router
   import cpu_mem_router_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 8,
   parameter int RAM_AW   = 17,
   parameter int TX_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] cpu_a,
   input  logic [DATA_W-1:0] cpu_dout,
   input  logic              cpu_wr,
   output logic [DATA_W-1:0] cpu_din,
   output logic              cpu_rdy,
   output logic [RAM_AW-1:0] ram_a,
   output logic [DATA_W-1:0] ram_dout,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_din,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              halted
);

   logic              io, off0, off4;
   logic              tx_full, tx_empty, tx_push, tx_pop;
   logic              rx_pop, rx_load;
   logic              rd_acc, wr_acc;

   logic              rx_full_q, rx_full_d;
   logic [DATA_W-1:0] rx_hold_q, rx_hold_d;
   logic              halted_q, halted_d;
   rd_src_e           src_q, src_d;
   logic [DATA_W-1:0] io_data_q, io_data_d;
   logic              fresh_q, fresh_d;
   logic [DATA_W-1:0] din_hold_q;
   logic [DATA_W-1:0] din_sel;

   assign io   = (cpu_a[17:16] == IO_SEL);
   assign off0 = (cpu_a[2:0] == IO_OFF_UART);
   assign off4 = (cpu_a[2:0] == IO_OFF_CTRL);

   assign cpu_rdy = rst & ~halted_q
                  & ~(io & cpu_wr & off0 & tx_full)
                  & ~(io & ~cpu_wr & off0 & ~rx_full_q);

   assign rd_acc = cpu_rdy & ~cpu_wr;
   assign wr_acc = cpu_rdy & cpu_wr;

   assign ram_a    = cpu_a[RAM_AW-1:0];
   assign ram_dout = cpu_dout;
   assign ram_we   = wr_acc & ~io;

   assign tx_push  = wr_acc & io & off0;
   assign tx_valid = ~tx_empty;
   assign tx_pop   = tx_valid & tx_ready;

   assign rx_ready = ~rx_full_q;
   assign rx_pop   = rd_acc & io & off0;
   // A pop only happens while full, so a same-cycle load is impossible; it lands next cycle.
   assign rx_load  = rx_valid & rx_ready;

   assign halted = halted_q;

   byte_fifo #(
      .DEPTH (TX_DEPTH),
      .WIDTH (DATA_W)
   ) u_tx_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (tx_push),
      .pop_i   (tx_pop),
      .din_i   (cpu_dout),
      .dout_o  (tx_data),
      .full_o  (tx_full),
      .empty_o (tx_empty)
   );

   always_comb begin
      rx_full_d = rx_full_q;
      rx_hold_d = rx_hold_q;
      halted_d  = halted_q;
      src_d     = src_q;
      io_data_d = io_data_q;
      fresh_d   = rd_acc;

      if (rx_pop) begin
         rx_full_d = 1'b0;
      end else if (rx_load) begin
         rx_full_d = 1'b1;
         rx_hold_d = rx_data;
      end

      if (wr_acc && io && off4) halted_d = 1'b1;

      if (rd_acc) begin
         if (!io) begin
            src_d = SRC_RAM;
         end else if (off0) begin
            src_d     = SRC_RX;
            io_data_d = rx_hold_q;
         end else if (off4) begin
            src_d     = SRC_STAT;
            io_data_d = DATA_W'(status_byte(tx_full, rx_full_q));
         end else begin
            src_d = SRC_ZERO;
         end
      end
   end

   // Fresh read data is shown for one cycle; otherwise the last shown value is held.
   always_comb begin
      din_sel = din_hold_q;
      if (fresh_q) begin
         unique case (src_q)
            SRC_RAM:  din_sel = ram_din;
            SRC_RX:   din_sel = io_data_q;
            SRC_STAT: din_sel = io_data_q;
            default:  din_sel = '0;
         endcase
      end
   end

   assign cpu_din = din_sel;

   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_full_q  <= 1'b0;
         rx_hold_q  <= '0;
         halted_q   <= 1'b0;
         src_q      <= SRC_ZERO;
         io_data_q  <= '0;
         fresh_q    <= 1'b0;
         din_hold_q <= '0;
      end else begin
         rx_full_q  <= rx_full_d;
         rx_hold_q  <= rx_hold_d;
         halted_q   <= halted_d;
         src_q      <= src_d;
         io_data_q  <= io_data_d;
         fresh_q    <= fresh_d;
         din_hold_q <= din_sel;
      end
   end

endmodule

// File: tb/tb_cpu_mem_router.sv
// Self-checking bench for cpu_mem_router: queue-based reference model plus directed scenarios.
module tb_cpu_mem_router;

   localparam int TXD = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] cpu_a = 32'h0;
   logic [7:0]  cpu_dout = 8'h0;
   logic        cpu_wr = 1'b0;
   logic [7:0]  cpu_din;
   logic        cpu_rdy;
   logic [16:0] ram_a;
   logic [7:0]  ram_dout;
   logic        ram_we;
   logic [7:0]  ram_din;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [7:0]  rx_data = 8'h0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        halted;

   int total = 0;
   int bad   = 0;

   cpu_mem_router dut (
      .clk      (clk),
      .rst      (rst),
      .cpu_a    (cpu_a),
      .cpu_dout (cpu_dout),
      .cpu_wr   (cpu_wr),
      .cpu_din  (cpu_din),
      .cpu_rdy  (cpu_rdy),
      .ram_a    (ram_a),
      .ram_dout (ram_dout),
      .ram_we   (ram_we),
      .ram_din  (ram_din),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .halted   (halted)
   );

   always #5 clk = ~clk;

   // Bench-side RAM with registered read port.
   logic [7:0] mem [0:131071] = '{default: 8'h00};
   always @(posedge clk) begin
      if (ram_we) mem[ram_a] <= ram_dout;
      ram_din <= mem[ram_a];
   end

   // Reference model state.
   logic [7:0] m_ram [0:131071] = '{default: 8'h00};
   logic [7:0] m_txq [$];
   bit         m_rxf  = 1'b0;
   logic [7:0] m_rxb  = 8'h00;
   bit         m_halt = 1'b0;
   logic [7:0] m_din  = 8'h00;
   bit         chk_en = 1'b0;
   logic [7:0] got [$];

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit m_io();
      return cpu_a[17:16] == 2'b11;
   endfunction

   function automatic bit m_rdy();
      if (rst !== 1'b1) return 1'b0;
      if (m_halt) return 1'b0;
      if (m_io() && cpu_a[2:0] == 3'd0) begin
         if (cpu_wr && m_txq.size() == TXD) return 1'b0;
         if (!cpu_wr && !m_rxf) return 1'b0;
      end
      return 1'b1;
   endfunction

   always @(posedge clk) begin : model
      bit         acc, io, full;
      logic [2:0] off;
      if (rst !== 1'b1) begin
         m_txq.delete();
         m_rxf  = 1'b0;
         m_halt = 1'b0;
         m_din  = 8'h00;
         chk_en = 1'b1;
      end else begin
         acc  = m_rdy();
         io   = m_io();
         off  = cpu_a[2:0];
         full = (m_txq.size() == TXD);
         if (acc && !cpu_wr) begin
            if (!io)            m_din = m_ram[cpu_a[16:0]];
            else if (off == 0)  m_din = m_rxb;
            else if (off == 4)  m_din = {6'b0, full, m_rxf};
            else                m_din = 8'h00;
         end
         if (acc && cpu_wr && !io) m_ram[cpu_a[16:0]] = cpu_dout;
         if (m_txq.size() > 0 && tx_ready) void'(m_txq.pop_front());
         if (acc && cpu_wr && io && off == 0) m_txq.push_back(cpu_dout);
         if (acc && !cpu_wr && io && off == 0) m_rxf = 1'b0;
         else if (rx_valid && !m_rxf) begin
            m_rxf = 1'b1;
            m_rxb = rx_data;
         end
         if (acc && cpu_wr && io && off == 4) m_halt = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cpu_rdy",  {7'b0, cpu_rdy},  {7'b0, m_rdy()});
         chk("cpu_din",  cpu_din,          m_din);
         chk("ram_we",   {7'b0, ram_we},   {7'b0, (cpu_wr && !m_io() && m_rdy())});
         chk("tx_valid", {7'b0, tx_valid}, {7'b0, (m_txq.size() > 0)});
         if (m_txq.size() > 0) chk("tx_data", tx_data, m_txq[0]);
         chk("rx_ready", {7'b0, rx_ready}, {7'b0, !m_rxf});
         chk("halted",   {7'b0, halted},   {7'b0, m_halt});
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [31:0] a, input logic w, input logic [7:0] d);
      cpu_a    = a;
      cpu_wr   = w;
      cpu_dout = d;
   endtask

   task automatic idle();
      set_req(32'h0003_0002, 1'b1, 8'h00);
   endtask

   // Present a request and hold it until accepted; returns just after the accepting edge.
   task automatic access(input logic [31:0] a, input logic w, input logic [7:0] d);
      int n;
      set_req(a, w, d);
      n = 0;
      #1;
      while (cpu_rdy !== 1'b1 && n < 60) begin
         cyc();
         #1;
         n++;
      end
      if (n >= 60) chk("access_timeout", {7'b0, cpu_rdy}, 8'h01);
      cyc();
   endtask

   task automatic drain();
      tx_ready = 1'b1;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (tx_valid !== 1'b1) break;
         got.push_back(tx_data);
         cyc();
      end
      tx_ready = 1'b0;
   endtask

   initial begin
      idle();
      repeat (3) cyc();
      chk("rst_rdy",      {7'b0, cpu_rdy},  8'h00);
      chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
      chk("rst_rx_ready", {7'b0, rx_ready}, 8'h01);
      chk("rst_halted",   {7'b0, halted},   8'h00);
      chk("rst_din",      cpu_din,          8'h00);
      rst = 1'b1;

      // RAM write then read-back
      set_req(32'h0000_0123, 1'b1, 8'hA5);
      #1;
      chk("ram_we_pulse", {7'b0, ram_we}, 8'h01);
      cyc();
      set_req(32'h0000_0123, 1'b0, 8'h00);
      #1;
      chk("ram_we_read", {7'b0, ram_we},  8'h00);
      chk("ram_rd_rdy",  {7'b0, cpu_rdy}, 8'h01);
      cyc();
      chk("ram_rd_data", cpu_din, 8'hA5);
      idle();

      // TX fill to full, stall on 9th, single pop releases it
      got.delete();
      tx_ready = 1'b0;
      for (int i = 1; i <= 8; i++) access(32'h0003_0000, 1'b1, 8'(i));
      set_req(32'h0003_0000, 1'b1, 8'h09);
      #1;
      chk("tx_full_stall", {7'b0, cpu_rdy}, 8'h00);
      cyc();
      #1;
      chk("tx_full_stall2", {7'b0, cpu_rdy}, 8'h00);
      tx_ready = 1'b1;
      #1;
      chk("tx_head", tx_data, 8'h01);
      got.push_back(tx_data);
      cyc();
      tx_ready = 1'b0;
      #1;
      chk("tx_9th_accept", {7'b0, cpu_rdy}, 8'h01);
      cyc();
      idle();
      drain();
      chk("tx_drain_cnt", 8'(got.size()), 8'd9);
      for (int i = 0; i < got.size(); i++) chk("tx_order", got[i], 8'(i + 1));

      // RX stall until a byte arrives
      cyc();
      set_req(32'h0003_0000, 1'b0, 8'h00);
      #1;
      chk("rx_empty_stall", {7'b0, cpu_rdy}, 8'h00);
      cyc();
      rx_data  = 8'h5C;
      rx_valid = 1'b1;
      #1;
      chk("rx_offer_stall", {7'b0, cpu_rdy}, 8'h00);
      cyc();
      rx_valid = 1'b0;
      #1;
      chk("rx_loaded_rdy", {7'b0, cpu_rdy},  8'h01);
      chk("rx_loaded_rr",  {7'b0, rx_ready}, 8'h00);
      cyc();
      chk("rx_data", cpu_din, 8'h5C);
      idle();

      // Status with TX and RX full, then after emptying both
      got.delete();
      for (int i = 0; i < 8; i++) access(32'h0003_0000, 1'b1, 8'h10 + 8'(i));
      idle();
      rx_data  = 8'h77;
      rx_valid = 1'b1;
      cyc();
      rx_valid = 1'b0;
      access(32'h0003_0004, 1'b0, 8'h00);
      chk("status_full", cpu_din, 8'h03);
      idle();
      drain();
      chk("stat_drain_cnt", 8'(got.size()), 8'd8);
      cyc();
      access(32'h0003_0000, 1'b0, 8'h00);
      chk("rx_pop_data", cpu_din, 8'h77);
      access(32'h0003_0004, 1'b0, 8'h00);
      chk("status_empty", cpu_din, 8'h00);
      access(32'h0003_0005, 1'b0, 8'h00);
      chk("unmapped_rd", cpu_din, 8'h00);

      // Halt with 3 bytes queued
      got.delete();
      for (int i = 0; i < 3; i++) access(32'h0003_0000, 1'b1, 8'hA1 + 8'(i));
      access(32'h0003_0004, 1'b1, 8'h00);
      chk("halt_set",  {7'b0, halted},  8'h01);
      chk("halt_rdy0", {7'b0, cpu_rdy}, 8'h00);
      idle();
      drain();
      chk("halt_drain_cnt", 8'(got.size()), 8'd3);
      for (int i = 0; i < got.size(); i++) chk("halt_order", got[i], 8'hA1 + 8'(i));
      cyc();
      chk("halt_sticky", {7'b0, cpu_rdy}, 8'h00);

      // Reset mid-stall with FIFO half full
      rst = 1'b0;
      cyc();
      rst = 1'b1;
      access(32'h0000_0123, 1'b0, 8'h00);
      chk("ram_rd_again", cpu_din, 8'hA5);
      for (int i = 0; i < 4; i++) access(32'h0003_0000, 1'b1, 8'hC0 + 8'(i));
      set_req(32'h0003_0000, 1'b0, 8'h00);
      cyc();
      cyc();
      rst = 1'b0;
      cyc();
      chk("mrst_tx_valid", {7'b0, tx_valid}, 8'h00);
      chk("mrst_rx_ready", {7'b0, rx_ready}, 8'h01);
      chk("mrst_halted",   {7'b0, halted},   8'h00);
      chk("mrst_din",      cpu_din,          8'h00);
      chk("mrst_rdy",      {7'b0, cpu_rdy},  8'h00);
      idle();
      rst = 1'b1;
      #1;
      chk("mrst_rdy_after", {7'b0, cpu_rdy}, 8'h01);
      repeat (3) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
